framebuffer_arbiter: RTL and testbench
======================================

// Module: framebuffer_arbiter
// PURPOSE
//  Sits in front of the 3-bit-per-pixel framebuffer RAM (17-bit addr, 1 write + 1 read port, 1-cycle registered read).
//  Shares the write port between a host pixel writer and an internal clear/fill engine.
//  Shares the read port between VGA scanout (absolute priority) and host readback.
//  Routes read data back to the requester.
// PARAMETERS
//  ADDR_W   17     framebuffer address width
//  PIX_W    3      pixel width (RGB, 1 bit each)
//  FB_DEPTH 76800  pixels in use (320x240); clear range and bounds limit
// PORTS
//  clock          in   1       system clock, all logic on posedge
//  reset_n        in   1       asynchronous, active-low reset
//  host_wr_valid  in   1       host write request
//  host_wr_ready  out  1       write accepted when valid&ready
//  host_wr_addr   in   ADDR_W  host write address
//  host_wr_data   in   PIX_W   host write pixel
//  host_rd_valid  in   1       host read request
//  host_rd_ready  out  1       read accepted when valid&ready
//  host_rd_addr   in   ADDR_W  host read address
//  host_rd_rvalid out  1       host read data valid (1-cycle pulse)
//  host_rd_rdata  out  PIX_W   host read data
//  vga_rd_en      in   1       scanout read strobe (never stalled)
//  vga_rd_addr    in   ADDR_W  scanout address
//  vga_rd_valid   out  1       scanout data valid
//  vga_rd_data    out  PIX_W   scanout pixel
//  clear_start    in   1       start fill; ignored unless idle
//  clear_color    in   PIX_W   fill colour, latched at start
//  clear_busy     out  1       fill in progress
//  clear_done     out  1       1-cycle pulse after last fill write
//  oob_err        out  1       sticky out-of-range host access flag
//  mem_we/mem_waddr/mem_wdata  out 1/ADDR_W/PIX_W  RAM write port (registered)
//  mem_re/mem_raddr            out 1/ADDR_W        RAM read port (combinational mux)
//  mem_rdata      in   PIX_W   RAM read data, valid the cycle after mem_re
// BEHAVIOUR
//  Reset: state IDLE, counter 0; mem_we, mem_re, clear_busy, clear_done, both rvalid/valid, oob_err = 0.
//  Reset: all data/address outputs = 0; host_wr_ready = 1 (state IDLE).
//  Write FSM IDLE:
//   - host_wr_ready = 1.
//   - Accepted host write drives mem_we=1 with its addr/data in the following cycle.
//   - clear_start -> CLEAR. Same-cycle host write is still accepted and issued before fill write 0.
//  Write FSM CLEAR:
//   - host_wr_ready = 0; one fill write per cycle, addr 0..FB_DEPTH-1, colour = latched clear_color.
//   - clear_start ignored. After addr FB_DEPTH-1 is issued: clear_done pulses, -> IDLE.
//  Read arbitration:
//   - host_rd_ready = ~vga_rd_en.
//   - mem_re = vga_rd_en | host_rd_valid; mem_raddr = vga ? vga_rd_addr : host_rd_addr.
//   - Source tag registered; next cycle exactly one of vga_rd_valid / host_rd_rvalid pulses with mem_rdata.
//   - Reads independent of write FSM; read-during-write same addr returns old data (RAM behaviour).
//  Reset mid-clear: fill aborts immediately, no clear_done, RAM left partially filled.
// CONFIGURATION
//  FBARB_BOUNDS_CHECK_EN defined:
//   - Host write with addr >= FB_DEPTH is accepted but no mem_we; oob_err set.
//   - Host read with addr >= FB_DEPTH is accepted, not issued to RAM; rvalid pulses with data 0; oob_err set.
//   - oob_err clears only on reset.
//  Not defined: addresses pass through unmodified; oob_err tied 0.
// STRUCTURE
//  fb_pkg: ADDR_W/PIX_W/FB_DEPTH constants, wr_state_t {IDLE,CLEAR}, rd_src_t {SRC_NONE,SRC_VGA,SRC_HOST}.
//  Sub-module fb_clear_engine: address counter, colour latch, busy/done generation.
// TESTING
//  1 write addr 5 data 3'b101 in IDLE -> next cycle mem_we=1, mem_waddr=5, mem_wdata=101; ready stays 1.
//  2 clear_start colour 3'b010 -> busy 76800 cycles, waddr 0..76799 consecutive, one clear_done, wr_ready 0 throughout.
//  3 vga_rd_en@100 + host_rd_valid@200 same cycle -> mem_raddr=100, host_rd_ready=0, vga_rd_valid next cycle.
//    Then host is served on the first vga-idle cycle, host_rd_rvalid +1.
//  4 reset_n low at fill addr 1000 -> clear_busy 0 at once, no done; new clear_start restarts at addr 0.
//  5 clear_start again at fill addr 10 -> ignored; fill completes at 76799 with a single clear_done.
//  6 host write addr 80000 -> with FBARB_BOUNDS_CHECK_EN: mem_we stays 0, oob_err=1 sticky.
//    Without the macro: mem_waddr=80000.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer arbiter and its clear engine.
// The optional bounds checker is enabled by defining FBARB_BOUNDS_CHECK_EN.
package fb_pkg;

  localparam int ADDR_W   = 17;
  localparam int PIX_W    = 3;
  localparam int FB_DEPTH = 76800;

  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } wr_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_VGA,
    SRC_HOST
  } rd_src_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr <= FB_LAST;
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Fill engine: sweeps addresses 0..FB_DEPTH-1 with a colour latched at start,
// flags the final address and produces a one-cycle done pulse.
module fb_clear_engine
  import fb_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              active_i,
  input  logic [PIX_W-1:0]  color_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [PIX_W-1:0]  color_o,
  output logic              last_o,
  output logic              done_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0]  color_q, color_d;
  logic              done_q, done_d;

  always_comb begin
    cnt_d   = cnt_q;
    color_d = color_q;
    if (start_i) begin
      cnt_d   = '0;
      color_d = color_i;
    end else if (active_i) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  assign last_o = active_i && (cnt_q == FB_LAST);
  // Done lines up with the last fill write appearing on the RAM port.
  assign done_d = last_o;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

  assign addr_o  = cnt_q;
  assign color_o = color_q;
  assign done_o  = done_q;

endmodule

// File: rtl/framebuffer_arbiter.sv
// Framebuffer port arbiter: host writes vs. clear engine on the write port,
// VGA scanout (priority) vs. host on the read port. Macro: FBARB_BOUNDS_CHECK_EN.
module framebuffer_arbiter
  import fb_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [PIX_W-1:0]  host_wr_data,
  input  logic              host_rd_valid,
  output logic              host_rd_ready,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              host_rd_rvalid,
  output logic [PIX_W-1:0]  host_rd_rdata,
  input  logic              vga_rd_en,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic              vga_rd_valid,
  output logic [PIX_W-1:0]  vga_rd_data,
  input  logic              clear_start,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              oob_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [PIX_W-1:0]  mem_rdata
);

  wr_state_t         state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [PIX_W-1:0]  wdata_q, wdata_d;
  rd_src_t           src_q, src_d;

  logic              wr_acc, wr_oob;
  logic              rd_acc, rd_oob;
  logic              fill_start, fill_active, fill_last, fill_done;
  logic [ADDR_W-1:0] fill_addr;
  logic [PIX_W-1:0]  fill_color;

  assign fill_start  = (state_q == IDLE) && clear_start;
  assign fill_active = (state_q == CLEAR);

  fb_clear_engine u_clear (
    .clock    (clock),
    .reset_n  (reset_n),
    .start_i  (fill_start),
    .active_i (fill_active),
    .color_i  (clear_color),
    .addr_o   (fill_addr),
    .color_o  (fill_color),
    .last_o   (fill_last),
    .done_o   (fill_done)
  );

  assign host_wr_ready = (state_q == IDLE);
  assign wr_acc        = host_wr_valid && host_wr_ready;
  assign host_rd_ready = ~vga_rd_en;
  assign rd_acc        = host_rd_valid && ~vga_rd_en;

`ifdef FBARB_BOUNDS_CHECK_EN
  assign wr_oob = wr_acc && !addr_in_range(host_wr_addr);
  assign rd_oob = rd_acc && !addr_in_range(host_rd_addr);
`else
  assign wr_oob = 1'b0;
  assign rd_oob = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        // A host write in the start cycle still lands before fill address 0.
        if (wr_acc && !wr_oob) begin
          we_d    = 1'b1;
          waddr_d = host_wr_addr;
          wdata_d = host_wr_data;
        end
        if (clear_start) state_d = CLEAR;
      end
      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = fill_addr;
        wdata_d = fill_color;
        if (fill_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_re    = vga_rd_en || (rd_acc && !rd_oob);
  assign mem_raddr = vga_rd_en ? vga_rd_addr : host_rd_addr;

  always_comb begin
    src_d = SRC_NONE;
    if (vga_rd_en)   src_d = SRC_VGA;
    else if (rd_acc) src_d = SRC_HOST;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
    end
  end

  assign mem_we         = we_q;
  assign mem_waddr      = waddr_q;
  assign mem_wdata      = wdata_q;
  assign clear_busy     = (state_q == CLEAR);
  assign clear_done     = fill_done;
  assign vga_rd_valid   = (src_q == SRC_VGA);
  assign vga_rd_data    = vga_rd_valid ? mem_rdata : '0;
  assign host_rd_rvalid = (src_q == SRC_HOST);

`ifdef FBARB_BOUNDS_CHECK_EN
  logic zero_q, oob_q;

  // Out-of-range host reads never reach the RAM, so their reply is forced to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zero_q <= 1'b0;
      oob_q  <= 1'b0;
    end else begin
      zero_q <= rd_oob;
      oob_q  <= oob_q || wr_oob || rd_oob;
    end
  end

  assign host_rd_rdata = (host_rd_rvalid && !zero_q) ? mem_rdata : '0;
  assign oob_err       = oob_q;
`else
  assign host_rd_rdata = host_rd_rvalid ? mem_rdata : '0;
  assign oob_err       = 1'b0;
`endif

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Self-checking bench for framebuffer_arbiter: randomized host/VGA traffic
// against a memory-level reference model, plus fill, abort and bounds scenarios.
module tb_framebuffer_arbiter;
  import fb_pkg::*;

`ifdef FBARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clock, reset_n;
  logic        host_wr_valid, host_wr_ready;
  logic [16:0] host_wr_addr;
  logic [2:0]  host_wr_data;
  logic        host_rd_valid, host_rd_ready;
  logic [16:0] host_rd_addr;
  logic        host_rd_rvalid;
  logic [2:0]  host_rd_rdata;
  logic        vga_rd_en;
  logic [16:0] vga_rd_addr;
  logic        vga_rd_valid;
  logic [2:0]  vga_rd_data;
  logic        clear_start;
  logic [2:0]  clear_color;
  logic        clear_busy, clear_done, oob_err;
  logic        mem_we, mem_re;
  logic [16:0] mem_waddr, mem_raddr;
  logic [2:0]  mem_wdata, mem_rdata;

  framebuffer_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .host_rd_addr(host_rd_addr), .host_rd_rvalid(host_rd_rvalid),
    .host_rd_rdata(host_rd_rdata),
    .vga_rd_en(vga_rd_en), .vga_rd_addr(vga_rd_addr),
    .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done), .oob_err(oob_err),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Framebuffer RAM driven by the DUT, and the bench's own expected contents.
  logic [2:0] ram     [0:131071];
  logic [2:0] ref_mem [0:131071];

  always @(posedge clock) begin
    if (mem_re) mem_rdata <= ram[mem_raddr];
    if (mem_we) ram[mem_waddr] <= mem_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected registered outputs for the cycle after the current one.
  logic        p_we, p_vv, p_hv, p_oob;
  logic [16:0] p_waddr;
  logic [2:0]  p_wdata, p_vdata, p_hdata;

  task automatic model_reset();
    p_we = 0; p_vv = 0; p_hv = 0; p_oob = 0;
    p_waddr = '0; p_wdata = '0; p_vdata = '0; p_hdata = '0;
  endtask

  // One idle-state cycle: drive, check against the model, advance the model.
  task automatic step(input logic wv, input logic [16:0] wa, input logic [2:0] wd,
                      input logic rv, input logic [16:0] ra,
                      input logic ve, input logic [16:0] va);
    logic w_ok, r_acc, r_ok;
    logic [2:0] n_vdata, n_hdata;
    host_wr_valid = wv; host_wr_addr = wa; host_wr_data = wd;
    host_rd_valid = rv; host_rd_addr = ra;
    vga_rd_en = ve; vga_rd_addr = va;
    #1;
    r_acc = rv && !ve;
    r_ok  = !BOUNDS || (int'(ra) < FB_DEPTH);
    w_ok  = !BOUNDS || (int'(wa) < FB_DEPTH);
    check_eq("wr_ready", host_wr_ready, 1);
    check_eq("rd_ready", host_rd_ready, !ve);
    check_eq("mem_re", mem_re, ve || (r_acc && r_ok));
    if (ve || (r_acc && r_ok)) check_eq("mem_raddr", mem_raddr, ve ? va : ra);
    check_eq("mem_we", mem_we, p_we);
    if (p_we) begin
      check_eq("mem_waddr", mem_waddr, p_waddr);
      check_eq("mem_wdata", mem_wdata, p_wdata);
    end
    check_eq("vga_valid", vga_rd_valid, p_vv);
    if (p_vv) check_eq("vga_data", vga_rd_data, p_vdata);
    check_eq("host_rvalid", host_rd_rvalid, p_hv);
    if (p_hv) check_eq("host_rdata", host_rd_rdata, p_hdata);
    check_eq("oob_err", oob_err, p_oob);
    // Reads see RAM contents before this cycle's write lands.
    n_vdata = ref_mem[va];
    n_hdata = r_ok ? ref_mem[ra] : 3'd0;
    p_oob   = p_oob | (BOUNDS && ((wv && !w_ok) || (r_acc && !r_ok)));
    @(posedge clock);
    if (p_we) ref_mem[p_waddr] = p_wdata;
    p_we = wv && w_ok; p_waddr = wa; p_wdata = wd;
    p_vv = ve; p_vdata = n_vdata;
    p_hv = r_acc; p_hdata = n_hdata;
    #1;
  endtask

  function automatic logic [16:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 17'($urandom_range(FB_DEPTH, 131071));
    return 17'($urandom_range(0, FB_DEPTH - 1));
  endfunction

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom_range(0, 1)), rnd_addr(), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), rnd_addr(),
           1'($urandom_range(0, 1)), 17'($urandom_range(0, 131071)));
  endtask

  initial begin
    int busy_cnt, seq_err, rdy_err, done_cnt, bad, cyc;
    logic [16:0] exp_addr;
    logic found, restart_sent;

    for (int i = 0; i < 131072; i++) begin
      ram[i] = 3'd0;
      ref_mem[i] = 3'd0;
    end
    reset_n = 0;
    host_wr_valid = 0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_valid = 0; host_rd_addr = '0;
    vga_rd_en = 0; vga_rd_addr = '0;
    clear_start = 0; clear_color = '0;
    model_reset();

    #23;
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_re", mem_re, 0);
    check_eq("rst_waddr", mem_waddr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_raddr", mem_raddr, 0);
    check_eq("rst_busy", clear_busy, 0);
    check_eq("rst_done", clear_done, 0);
    check_eq("rst_vvalid", vga_rd_valid, 0);
    check_eq("rst_hrvalid", host_rd_rvalid, 0);
    check_eq("rst_vdata", vga_rd_data, 0);
    check_eq("rst_hrdata", host_rd_rdata, 0);
    check_eq("rst_oob", oob_err, 0);
    check_eq("rst_wr_ready", host_wr_ready, 1);
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;

    // Single host write in idle.
    step(1, 17'd5, 3'b101, 0, '0, 0, '0);
    check_eq("t1_we", mem_we, 1);
    check_eq("t1_waddr", mem_waddr, 5);
    check_eq("t1_wdata", mem_wdata, 3'b101);
    check_eq("t1_ready", host_wr_ready, 1);

    // Seed known pixels, then VGA/host read collision.
    step(1, 17'd100, 3'b011, 0, '0, 0, '0);
    step(1, 17'd200, 3'b110, 0, '0, 0, '0);
    step(0, '0, '0, 0, '0, 0, '0);
    step(0, '0, '0, 1, 17'd200, 1, 17'd100);
    check_eq("t3_vvalid", vga_rd_valid, 1);
    check_eq("t3_vdata", vga_rd_data, 3'b011);
    check_eq("t3_hrvalid", host_rd_rvalid, 0);
    step(0, '0, '0, 1, 17'd200, 0, '0);
    check_eq("t3_hrvalid2", host_rd_rvalid, 1);
    check_eq("t3_hrdata", host_rd_rdata, 3'b110);

    // Out-of-range host write and read.
    step(1, 17'd80000, 3'b101, 0, '0, 0, '0);
`ifdef FBARB_BOUNDS_CHECK_EN
    check_eq("t6_we", mem_we, 0);
    check_eq("t6_oob", oob_err, 1);
`else
    check_eq("t6_we", mem_we, 1);
    check_eq("t6_waddr", mem_waddr, 80000);
`endif
    step(0, '0, '0, 1, 17'd90000, 0, '0);
    step(0, '0, '0, 0, '0, 0, '0);

    random_phase(1500);
    step(0, '0, '0, 0, '0, 0, '0);
    step(0, '0, '0, 0, '0, 0, '0);

    // Reset in the middle of a fill.
    host_wr_valid = 0; host_rd_valid = 0; vga_rd_en = 0;
    clear_start = 1; clear_color = 3'b011;
    @(posedge clock); #1;
    clear_start = 0;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (mem_we && mem_waddr == 17'd1000) found = 1;
      else begin @(posedge clock); #1; end
    end
    check_eq("t4_reach1000", found, 1);
    reset_n = 0;
    #1;
    check_eq("t4_busy", clear_busy, 0);
    check_eq("t4_done", clear_done, 0);
    check_eq("t4_we", mem_we, 0);
    check_eq("t4_oob", oob_err, 0);
    check_eq("t4_ready", host_wr_ready, 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check_eq("t4_nodone", clear_done, 0);
    end
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;
    check_eq("t4_done_after", clear_done, 0);
    for (int i = 0; i < 1000; i++) ref_mem[i] = 3'b011;
    check_eq("t4_ram0", ram[0], ref_mem[0]);
    check_eq("t4_ram999", ram[999], ref_mem[999]);
    check_eq("t4_ram1000", ram[1000], ref_mem[1000]);
    model_reset();

    // Full fill with a same-cycle host write and an ignored restart.
    clear_start = 1; clear_color = 3'b010;
    host_wr_valid = 1; host_wr_addr = 17'd7; host_wr_data = 3'b110;
    @(posedge clock); #1;
    clear_start = 0; clear_color = 3'b111;
    host_wr_addr = 17'd9; host_wr_data = 3'b001;
    check_eq("t2_host_we", mem_we, 1);
    check_eq("t2_host_waddr", mem_waddr, 7);
    check_eq("t2_host_wdata", mem_wdata, 3'b110);
    check_eq("t2_busy0", clear_busy, 1);
    check_eq("t2_ready0", host_wr_ready, 0);
    busy_cnt = 1; seq_err = 0; rdy_err = 0; done_cnt = 0;
    exp_addr = '0; restart_sent = 0; cyc = 0;
    while (done_cnt == 0 && cyc < 80000) begin
      @(posedge clock); #1;
      cyc++;
      clear_start = 0;
      if (clear_busy) busy_cnt++;
      if (clear_busy && host_wr_ready) rdy_err++;
      if (mem_we) begin
        if (mem_waddr != exp_addr || mem_wdata != 3'b010) seq_err++;
        exp_addr++;
      end
      if (clear_done) begin
        done_cnt++;
        host_wr_valid = 0;
      end
      if (mem_we && mem_waddr == 17'd10 && !restart_sent) begin
        clear_start = 1;
        restart_sent = 1;
      end
    end
    check_eq("t2_done_cnt", done_cnt, 1);
    check_eq("t2_busy_cycles", busy_cnt, FB_DEPTH);
    check_eq("t2_fill_writes", exp_addr, FB_DEPTH);
    check_eq("t2_seq_err", seq_err, 0);
    check_eq("t2_ready_err", rdy_err, 0);
    check_eq("t5_restart_seen", restart_sent, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check_eq("t2_tail_done", clear_done, 0);
      check_eq("t2_tail_we", mem_we, 0);
      check_eq("t2_tail_busy", clear_busy, 0);
    end
    bad = 0;
    for (int i = 0; i < FB_DEPTH; i++) begin
      if (ram[i] !== 3'b010) bad++;
      ref_mem[i] = 3'b010;
    end
    check_eq("t2_ram_fill", bad, 0);
    check_eq("t2_ram_beyond", ram[FB_DEPTH], ref_mem[FB_DEPTH]);

    random_phase(300);
    step(0, '0, '0, 0, '0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
